// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// master drives operands and result acceptance; slave is the datapath.
interface serial_subtractor_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per cycle, LSB first.
// Result emerges after WIDTH cycles and is held until handshaken.
module serial_subtractor #(
  parameter int WIDTH = 32
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave s
);
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           st;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] res;
  logic             bf;
  logic [CW-1:0]    cnt;
  logic             rdy;
  logic             vld;

  logic ai;
  logic bi;
  logic d;
  logic bout;

  assign ai   = ra[0];
  assign bi   = rb[0];
  assign d    = ai ^ bi ^ bf;
  assign bout = (~ai & bi) | (~(ai ^ bi) & bf);

  assign s.in_ready  = rdy;
  assign s.out_valid = vld;
  assign s.diff      = res;
  assign s.borrow    = bf;

  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= IDLE;
      ra  <= '0;
      rb  <= '0;
      res <= '0;
      bf  <= 1'b0;
      cnt <= '0;
      rdy <= 1'b1;
      vld <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (s.in_valid) begin
            ra  <= s.a;
            rb  <= s.b;
            res <= '0;
            bf  <= 1'b0;
            cnt <= '0;
            rdy <= 1'b0;
            st  <= RUN;
          end
        end
        RUN: begin
          // difference bits enter at the MSB and walk down to bit 0
          res <= {d, res[WIDTH-1:1]};
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          bf  <= bout;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            vld <= 1'b1;
            st  <= DONE;
          end
        end
        DONE: begin
          if (s.out_ready) begin
            res <= '0;
            bf  <= 1'b0;
            cnt <= '0;
            vld <= 1'b0;
            rdy <= 1'b1;
            st  <= IDLE;
          end
        end
        default: begin
          st  <= IDLE;
          rdy <= 1'b1;
          vld <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8.
// Vector table, corner-case sequences and a random back-to-back run.
module tb_serial_subtractor;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         br;
  } vec_t;

  typedef struct {
    logic [W-1:0] d;
    logic         br;
  } exp_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  exp_t q[$];
  vec_t tbl[8];

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic tmo(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: timeout", nm);
  endtask

  task automatic do_accept(input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic [W-1:0] ed, input logic eb,
                           input bit push);
    int n;
    exp_t e;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) tmo("accept_wait");
    bus.a = av;
    bus.b = bv;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (push) begin
      e.d = ed;
      e.br = eb;
      q.push_back(e);
    end
  endtask

  // waits for out_valid, checks latency and the popped expectation
  task automatic collect(input string nm, input bit scramble);
    int n;
    exp_t e;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      if (scramble) begin
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
        bus.in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (!bus.out_valid) begin
      tmo({nm, "_outvalid"});
      return;
    end
    chk({nm, "_latency"}, 64'(n), 64'(W));
    chk({nm, "_inready_done"}, 64'(bus.in_ready), 64'd0);
    if (q.size() == 0) begin
      tmo({nm, "_scoreboard_empty"});
      return;
    end
    e = q.pop_front();
    chk({nm, "_diff"}, 64'(bus.diff), 64'(e.d));
    chk({nm, "_borrow"}, 64'(bus.borrow), 64'(e.br));
    if (bus.out_ready) begin
      @(posedge clk);
      #1;
      chk({nm, "_idle_ready"}, 64'(bus.in_ready), 64'd1);
      chk({nm, "_idle_valid"}, 64'(bus.out_valid), 64'd0);
      chk({nm, "_idle_diff"}, 64'(bus.diff), 64'd0);
      chk({nm, "_idle_borrow"}, 64'(bus.borrow), 64'd0);
    end
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] rd;
    exp_t e;
    bit rdy;
    int pushed;
    int popped;
    int last;

    tests = 0;
    fails = 0;
    tbl[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
    tbl[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
    tbl[2] = '{8'h00, 8'hFF, 8'h01, 1'b1};
    tbl[3] = '{8'hA5, 8'hA5, 8'h00, 1'b0};
    tbl[4] = '{8'h80, 8'h00, 8'h80, 1'b0};
    tbl[5] = '{8'hFF, 8'h01, 8'hFE, 1'b0};
    tbl[6] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    tbl[7] = '{8'h7F, 8'h80, 8'hFF, 1'b1};

    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.a = 8'hEE;
    bus.b = 8'h11;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_diff", 64'(bus.diff), 64'd0);
    chk("rst_borrow", 64'(bus.borrow), 64'd0);

    // first edge with rst low must already accept
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      do_accept(tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].br, 1'b1);
      collect($sformatf("vec%0d", i), i[0]);
    end

    // backpressure: result held, in_valid ignored
    bus.out_ready = 1'b0;
    do_accept(8'h33, 8'h44, 8'hEF, 1'b1, 1'b1);
    collect("bp", 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.a = 8'h99;
      bus.b = 8'h11;
      @(posedge clk);
      #1;
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_diff", 64'(bus.diff), 64'hEF);
      chk("bp_borrow", 64'(bus.borrow), 64'd1);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
    chk("bp_release_valid", 64'(bus.out_valid), 64'd0);

    // reset on the 4th RUN cycle discards the operation
    do_accept(8'h55, 8'h22, 8'h33, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_diff", 64'(bus.diff), 64'd0);
    do_accept(8'h10, 8'h01, 8'h0F, 1'b0, 1'b1);
    collect("post_rst", 1'b0);

    // random back-to-back with in_valid held high
    ra = 8'($urandom);
    rb = 8'($urandom);
    bus.a = ra;
    bus.b = rb;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    pushed = 0;
    popped = 0;
    last = -1;
    for (int cyc = 0; cyc < 10200 && popped < 1000; cyc++) begin
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (rdy && pushed < 1000) begin
        rd = ra - rb;
        e.d = rd;
        e.br = (ra < rb);
        q.push_back(e);
        if (last >= 0) chk("b2b_spacing", 64'(cyc - last), 64'd10);
        last = cyc;
        pushed++;
        if (pushed == 1000) begin
          bus.in_valid = 1'b0;
        end else begin
          ra = 8'($urandom);
          rb = 8'($urandom);
          bus.a = ra;
          bus.b = rb;
        end
      end
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          tmo("b2b_scoreboard_empty");
        end else begin
          e = q.pop_front();
          chk("b2b_diff", 64'(bus.diff), 64'(e.d));
          chk("b2b_borrow", 64'(bus.borrow), 64'(e.br));
        end
        popped++;
      end
    end
    bus.in_valid = 1'b0;
    if (popped < 1000) tmo("b2b_results");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
